// File: rtl/axi_mux_rr_4.sv
// axi_mux_rr_4: packet-aware round-robin merge of four AXI-Stream sources
// onto one registered AXI-Stream output. A grant is held from the first
// beat of a packet through its tlast beat. m_axis_tuser carries the
// index of the source that produced each output beat.
module axi_mux_rr_4 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic [3:0]            port_enable,

    input  logic                  s0_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,

    input  logic                  s1_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,

    input  logic                  s2_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s2_axis_tdata,
    input  logic                  s2_axis_tlast,
    output logic                  s2_axis_tready,

    input  logic                  s3_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s3_axis_tdata,
    input  logic                  s3_axis_tlast,
    output logic                  s3_axis_tready,

    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [1:0]            m_axis_tuser,
    input  logic                  m_axis_tready,

    output logic                  busy
);

    typedef enum logic {
        ARB    = 1'b0,
        PACKET = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              grant;
    logic [1:0]              grant_nxt;
    logic [1:0]              last_grant;
    logic [1:0]              last_grant_nxt;

    logic [3:0]              s_tvalid;
    logic [3:0]              s_tlast;
    logic [3:0]              s_tready;
    logic [DATA_WIDTH-1:0]   s_tdata [4];
    logic [3:0]              req;

    logic                    adv;
    logic                    vld_p0;
    logic [DATA_WIDTH-1:0]   data_p0;
    logic                    last_p0;

    logic                    vld_p1;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic                    last_p1;
    logic [1:0]              user_p1;

    // First requesting source after 'last', scanning last+1 .. last+4 mod 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign s_tvalid   = {s3_axis_tvalid, s2_axis_tvalid, s1_axis_tvalid, s0_axis_tvalid};
    assign s_tlast    = {s3_axis_tlast,  s2_axis_tlast,  s1_axis_tlast,  s0_axis_tlast};
    assign s_tdata[0] = s0_axis_tdata;
    assign s_tdata[1] = s1_axis_tdata;
    assign s_tdata[2] = s2_axis_tdata;
    assign s_tdata[3] = s3_axis_tdata;

    // Only enabled sources compete; the mask only matters while arbitrating.
    assign req = s_tvalid & port_enable;

    // Stage p0: beat accepted from the granted source when the output slot frees up
    assign adv     = ~vld_p1 | m_axis_tready;
    assign vld_p0  = (state == PACKET) & s_tvalid[grant] & adv;
    assign data_p0 = s_tdata[grant];
    assign last_p0 = s_tlast[grant];

    // Ready goes only to the granted source and never looks at source tvalid.
    always_comb begin
        s_tready = '0;
        if (state == PACKET) begin
            s_tready[grant] = adv;
        end
    end

    assign s0_axis_tready = s_tready[0];
    assign s1_axis_tready = s_tready[1];
    assign s2_axis_tready = s_tready[2];
    assign s3_axis_tready = s_tready[3];

    // Control registers: arbitration state, current grant and priority pointer.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state      <= ARB;
            grant      <= 2'd0;
            last_grant <= 2'd3;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next-state logic: pick a winner in ARB, hold it until its tlast is accepted.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        case (state)
            ARB: begin
                if (req != 4'b0000) begin
                    grant_nxt = rr_pick(req, last_grant);
                    state_nxt = PACKET;
                end
            end
            PACKET: begin
                if (vld_p0 && last_p0) begin
                    last_grant_nxt = grant;
                    state_nxt      = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // Stage p1: output register, loads on accept, drains when downstream takes the beat
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
            user_p1 <= 2'd0;
        end else if (vld_p0) begin
            vld_p1  <= 1'b1;
            data_p1 <= data_p0;
            last_p1 <= last_p0;
            user_p1 <= grant;
        end else if (m_axis_tready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign m_axis_tvalid = vld_p1;
    assign m_axis_tdata  = data_p1;
    assign m_axis_tlast  = last_p1;
    assign m_axis_tuser  = user_p1;
    assign busy          = (state == PACKET);

endmodule

// File: tb/tb_axi_mux_rr_4.sv
// Testbench for axi_mux_rr_4: per-source packet generators, a packet-level
// round-robin reference model and a scoreboard that checks every output beat.
module tb_axi_mux_rr_4;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          sync_reset;
    logic [3:0]    port_enable;
    logic [3:0]    s_tvalid;
    logic [3:0]    s_tlast;
    logic [DW-1:0] s_tdata [4];
    wire  [3:0]    s_tready;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic [1:0]    m_tuser;
    logic          m_tready;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // generator controls
    int          left [4];
    int          budget [4];
    int          plen [4];
    int          acc_cnt [4];
    logic [31:0] seq_data [4];
    int          gap_pct;
    int          rdy_mode;
    int          rpat;
    bit          chk_idle;

    // scoreboard: accepted source beats {tlast,tdata} and expected grants
    logic [32:0] src_q [4][$];
    logic [1:0]  grant_q [$];

    axi_mux_rr_4 #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .sync_reset(sync_reset), .port_enable(port_enable),
        .s0_axis_tvalid(s_tvalid[0]), .s0_axis_tdata(s_tdata[0]), .s0_axis_tlast(s_tlast[0]), .s0_axis_tready(s_tready[0]),
        .s1_axis_tvalid(s_tvalid[1]), .s1_axis_tdata(s_tdata[1]), .s1_axis_tlast(s_tlast[1]), .s1_axis_tready(s_tready[1]),
        .s2_axis_tvalid(s_tvalid[2]), .s2_axis_tdata(s_tdata[2]), .s2_axis_tlast(s_tlast[2]), .s2_axis_tready(s_tready[2]),
        .s3_axis_tvalid(s_tvalid[3]), .s3_axis_tdata(s_tdata[3]), .s3_axis_tlast(s_tlast[3]), .s3_axis_tready(s_tready[3]),
        .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser), .m_axis_tready(m_tready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration rule: first requester after the last granted source.
    function automatic logic [1:0] rr_model(input logic [3:0] r, input logic [1:0] last);
        int cand;
        for (int k = 1; k <= 4; k++) begin
            cand = (int'(last) + k) % 4;
            if (r[cand]) return 2'(cand);
        end
        return last;
    endfunction

    // Source generators and downstream ready driver.
    initial begin : driver
        logic [3:0] acc;
        forever begin
            @(negedge clk);
            for (int n = 0; n < 4; n++) begin
                acc[n] = s_tvalid[n] & s_tready[n] & ~sync_reset;
                if (acc[n]) begin
                    src_q[n].push_back({s_tlast[n], s_tdata[n]});
                    acc_cnt[n]++;
                end
            end
            @(posedge clk);
            #1;
            for (int n = 0; n < 4; n++) begin
                if (acc[n]) begin
                    left[n]--;
                    s_tvalid[n] = 1'b0;
                end
                if (!s_tvalid[n]) begin
                    if (left[n] == 0 && budget[n] > 0) begin
                        left[n] = (plen[n] > 0) ? plen[n] : int'($urandom_range(1, 6));
                        budget[n]--;
                    end
                    if (left[n] > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
                        s_tvalid[n] = 1'b1;
                        s_tdata[n]  = seq_data[n];
                        seq_data[n] = seq_data[n] + 32'd1;
                        s_tlast[n]  = (left[n] == 1);
                    end
                end
            end
            case (rdy_mode)
                1: begin
                    m_tready = (rpat == 0);
                    rpat     = (rpat + 1) % 3;
                end
                2:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 1'b1;
            endcase
        end
    end

    // Monitor: grant model, scoreboard and per-cycle protocol checks.
    initial begin : monitor
        logic        p_hold;
        logic [35:0] p_fields;
        logic        p1_last, p2_last, p1_idle;
        logic [3:0]  p1_req, p2_req, req;
        logic [1:0]  owner, exp_g, model_last;
        logic [32:0] e;
        bit          in_pkt;
        p_hold = 0; p_fields = '0; p1_last = 0; p2_last = 0; p1_idle = 0;
        p1_req = '0; p2_req = '0; owner = '0; model_last = 2'd3; in_pkt = 0;
        forever begin
            @(negedge clk);
            req = s_tvalid & port_enable;
            if (sync_reset) begin
                for (int n = 0; n < 4; n++) src_q[n].delete();
                grant_q.delete();
                model_last = 2'd3;
                in_pkt  = 0;
                p_hold  = 0;
                p1_last = 0;
                p2_last = 0;
            end else begin
                if (p_hold) begin
                    chk("hold_valid", m_tvalid, 1'b1);
                    chk("hold_fields", {m_tlast, m_tuser, m_tdata}, p_fields);
                end
                if (!busy) chk("arb_tready", s_tready, 4'b0000);
                if (m_tvalid && !m_tready) chk("bp_tready", s_tready, 4'b0000);
                if (chk_idle) begin
                    if (p1_last) chk("idle_gap", m_tvalid, 1'b0);
                    if (p2_last && p1_idle && p2_req != 4'b0000) chk("one_idle", m_tvalid, 1'b1);
                end
                if (m_tvalid && m_tready) begin
                    if (!in_pkt) begin
                        chk("grant_pending", grant_q.size() != 0, 1'b1);
                        if (grant_q.size() != 0) begin
                            exp_g = grant_q.pop_front();
                            chk("grant", m_tuser, exp_g);
                            owner = exp_g;
                        end else begin
                            owner = m_tuser;
                        end
                        in_pkt = 1;
                    end else begin
                        chk("no_interleave", m_tuser, owner);
                    end
                    chk("beat_avail", src_q[owner].size() != 0, 1'b1);
                    if (src_q[owner].size() != 0) begin
                        e = src_q[owner].pop_front();
                        chk("beat", {m_tlast, m_tdata}, e);
                    end
                    if (m_tlast) in_pkt = 0;
                end
                if (!busy && req != 4'b0000) begin
                    exp_g = rr_model(req, model_last);
                    grant_q.push_back(exp_g);
                    model_last = exp_g;
                end
                p2_last  = p1_last;
                p1_last  = m_tvalid & m_tready & m_tlast;
                p1_idle  = ~m_tvalid;
                p2_req   = p1_req;
                p1_req   = req;
                p_hold   = m_tvalid & ~m_tready;
                p_fields = {m_tlast, m_tuser, m_tdata};
            end
        end
    end

    task automatic pulse_reset();
        @(posedge clk); #2;
        sync_reset = 1'b1;
        @(posedge clk); #2;
        sync_reset = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        bit done;
        int pend;
        done = 0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            #1;
            pend = 0;
            for (int n = 0; n < 4; n++) pend += left[n] + budget[n];
            done = (s_tvalid == 4'b0000) && !m_tvalid && !busy && (pend == 0);
        end
        chk("drain", done, 1'b1);
        chk("sb_empty", src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() + grant_q.size(), 0);
    endtask

    initial begin : main
        int  base0, base1, base02;
        bit  seen;
        sync_reset = 1'b1; port_enable = 4'hF; s_tvalid = '0; s_tlast = '0;
        m_tready = 1'b1; gap_pct = 0; rdy_mode = 0; rpat = 0; chk_idle = 0;
        for (int n = 0; n < 4; n++) begin
            s_tdata[n] = '0; left[n] = 0; budget[n] = 0; plen[n] = 0; acc_cnt[n] = 0;
            seq_data[n] = 32'(n) << 24;
        end

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tdata", m_tdata, 32'h0);
        chk("rst_tlast", m_tlast, 1'b0);
        chk("rst_tuser", m_tuser, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tready", s_tready, 4'b0000);
        @(posedge clk); #2;
        sync_reset = 1'b0;
        repeat (2) @(posedge clk);

        // single 4-beat packet from source 2, cycle-exact
        #2;
        seq_data[2] = 32'hA0; plen[2] = 4; budget[2] = 1;
        @(posedge clk);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("t1_busy_c%0d", k), busy, (k >= 1 && k <= 4));
            chk($sformatf("t1_tvalid_c%0d", k), m_tvalid, (k >= 2 && k <= 5));
            if (m_tvalid) begin
                chk($sformatf("t1_tuser_c%0d", k), m_tuser, 2'd2);
                chk($sformatf("t1_tlast_c%0d", k), m_tlast, (k == 5));
                chk($sformatf("t1_tdata_c%0d", k), m_tdata, 32'hA0 + 32'(k - 2));
            end
        end
        wait_drain(100);

        // all four sources contend with 2-beat packets
        pulse_reset();
        #1;
        chk_idle = 1;
        for (int n = 0; n < 4; n++) begin plen[n] = 2; budget[n] = 5; end
        wait_drain(400);
        chk_idle = 0;

        // backpressure on an 8-beat packet from source 1
        #1;
        base1 = acc_cnt[1];
        rdy_mode = 1; rpat = 0; plen[1] = 8; budget[1] = 1;
        wait_drain(300);
        chk("t3_beats", acc_cnt[1] - base1, 8);
        rdy_mode = 0;

        // enable mask 1010, then drop source 1 mid-packet
        #1;
        base1  = acc_cnt[1];
        base02 = acc_cnt[0] + acc_cnt[2];
        rdy_mode = 2; port_enable = 4'b1010;
        for (int n = 0; n < 4; n++) plen[n] = 4;
        budget[0] = 1; budget[2] = 1; budget[1] = 3; budget[3] = 3;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = s_tready[1] & s_tvalid[1];
        end
        chk("t4_src1_granted", seen, 1'b1);
        @(posedge clk); #2;
        port_enable = 4'b1000;
        repeat (100) @(posedge clk);
        #2;
        chk("t4_src1_beats", acc_cnt[1] - base1, 4);
        chk("t4_masked", acc_cnt[0] + acc_cnt[2] - base02, 0);
        budget[1] = 0;
        port_enable = 4'hF;
        rdy_mode = 0;
        wait_drain(400);

        // reset on beat 3 of a 6-beat packet from source 0
        #1;
        base0 = acc_cnt[0];
        plen[0] = 6; budget[0] = 1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk); #1;
            seen = (acc_cnt[0] - base0 == 2);
        end
        chk("t5_two_beats", seen, 1'b1);
        @(posedge clk); #2;
        sync_reset = 1'b1;
        plen[1] = 2; budget[1] = 1;
        @(posedge clk); #2;
        sync_reset = 1'b0;
        @(negedge clk);
        chk("t5_tvalid", m_tvalid, 1'b0);
        chk("t5_tready", s_tready, 4'b0000);
        chk("t5_busy", busy, 1'b0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = m_tvalid;
        end
        chk("t5_first_seen", seen, 1'b1);
        chk("t5_first_src", m_tuser, 2'd0);
        wait_drain(200);
        chk("t5_src0_beats", acc_cnt[0] - base0, 6);

        // wrap: last_grant=3, only sources 3 and 0 request
        pulse_reset();
        #1;
        chk_idle = 1;
        plen[0] = 3; plen[3] = 3; budget[0] = 1; budget[3] = 1;
        wait_drain(100);
        chk_idle = 0;

        // randomized traffic with random ready and enable changes
        #1;
        gap_pct = 30; rdy_mode = 2;
        for (int n = 0; n < 4; n++) begin
            plen[n] = 0; budget[n] = 8; seq_data[n] = $urandom;
        end
        for (int r = 0; r < 20; r++) begin
            repeat (15) @(posedge clk);
            #2;
            port_enable = 4'($urandom_range(0, 15));
        end
        port_enable = 4'hF;
        wait_drain(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_mux_rr_4.md
# axi_mux_rr_4

Packet-aware, round-robin arbiter that merges four AXI-Stream sources onto one AXI-Stream output. Each source is typically the master side of a channelizer FIFO. Grants are held for a whole packet, from the first beat through the beat with tlast, so packets are never interleaved. The output carries the source index in m_axis_tuser so downstream logic can demultiplex or tag channels.

## Interface
- DATA_WIDTH, 32, width of every tdata bus
- clk  in  1  system clock; all logic is rising-edge
- sync_reset  in  1  synchronous, active-high reset
- port_enable  in  4  per-source enable mask; bit n=0 excludes source n from new grants
- sN_axis_tvalid  in  1  source N valid, for N = 0..3
- sN_axis_tdata  in  DATA_WIDTH  source N data
- sN_axis_tlast  in  1  source N end of packet
- sN_axis_tready  out  1  source N ready
- m_axis_tvalid  out  1  output valid
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tlast  out  1  output end of packet
- m_axis_tuser  out  2  index of the source that produced the current beat
- m_axis_tready  in  1  downstream ready
- busy  out  1  high while a packet grant is held (state PACKET)

## Operation
- There are two states, ARB and PACKET. The grant register is 2 bits. The priority pointer last_grant is 2 bits.
- **ARB**
  - Build the request vector req[n] = sN_axis_tvalid & port_enable[n].
  - If req is nonzero, select the first set bit scanning last_grant+1, +2, +3, +4 (mod 4). Register it in grant and go to PACKET.
  - If req is zero, stay in ARB.
  - No source is ready in ARB.
- **PACKET**
  - Define adv = ~m_axis_tvalid | m_axis_tready.
  - s[grant]_axis_tready = adv. All other sources' tready = 0.
  - A beat is accepted when s[grant] tvalid & tready. The accepted beat loads the output register: tdata, tlast, tuser = grant, and tvalid = 1.
  - If the accepted beat has tlast=1, set last_grant = grant and go to ARB on the next cycle.
- **Output register**
  - It clears tvalid when m_axis_tready=1 and no new beat is loaded that cycle.
  - It holds all fields while tvalid=1 and m_axis_tready=0.
- **port_enable behaviour**
  - port_enable is sampled only in ARB.
  - Clearing the bit of the granted source mid-packet does not abort the packet.
- **Non-inputs**
  - There is no timeout. A source that never asserts tlast holds the grant indefinitely.
- **Reset**
  - State = ARB, last_grant = 3 (source 0 has top priority first), grant = 0.
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0, m_axis_tuser = 0.
  - All sN_axis_tready = 0, busy = 0.
  - Reset mid-packet drops the grant and any beat held in the output register. The source's remaining beats are later arbitrated as a new packet.

## Timing
- Arbitration costs one cycle. The first source beat is accepted on the first PACKET cycle, one cycle after ARB sees the request. m_axis_tvalid rises on the following cycle.
  - Best case, request to m_axis_tvalid is 2 clocks.
- Steady-state throughput is one beat per clock within a packet while m_axis_tready=1.
- There is one idle output cycle between consecutive packets, caused by the ARB cycle. A 1-beat packet therefore occupies 2 cycles.
- Ready timing:
  - sN_axis_tready depends combinationally on m_axis_tready, state and grant only.
  - It never depends on sN_axis_tvalid.
- m_axis_* outputs are registered. They change only when a beat is loaded or the register drains.
- When tlast is accepted and another source is already requesting:
  - the next grant is decided in the ARB cycle directly after;
  - that source's first beat is accepted one cycle later.
- busy = 1 exactly in PACKET cycles.

## Test plan
- **Single packet.** After reset, source 2 sends a 4-beat packet (tdata 0xA0..0xA3, tlast on 0xA3) with m_axis_tready=1. Required:
  - busy rises on cycle 1;
  - m_axis_tvalid is high for cycles 2..5 with tuser=2;
  - tlast on cycle 5 only;
  - busy falls on cycle 5.
- **All sources contend.** All four sources hold continuous 2-beat packets. Required:
  - grant order is 0,1,2,3,0,…;
  - packets are never interleaved;
  - there is exactly one idle output cycle per packet boundary.
- **Backpressure.** Source 1 sends an 8-beat packet while m_axis_tready toggles 1,0,0,1,… Required:
  - m_axis_tdata/tlast/tuser stay stable while tvalid=1 and tready=0;
  - s1_axis_tready = 0 on those cycles;
  - all 8 beats arrive in order.
- **Enable mask.** port_enable=4'b1010 with all sources requesting gives grants to 1 and 3 only. Clearing bit 1 mid-packet on source 1 lets that packet finish. Source 1 is then skipped.
- **Reset mid-packet.** Assert sync_reset on beat 3 of 6 from source 0. Required, on the next cycle:
  - m_axis_tvalid = 0, all tready = 0, busy = 0, state ARB;
  - the next grant goes to source 0, because last_grant = 3.
- **Back-to-back wrap.** last_grant=3 and only sources 3 and 0 request. Required: 0 is granted before 3, and 3 follows immediately after 0's tlast.
